cla_multiword_sequencer: RTL

- Adds two wide operands (WIDTH*NUM_CHUNKS bits) plus a carry-in on a single narrow Carry_LookAhead_Adder instance, one WIDTH-bit chunk per clock, LSB chunk first.
- The inter-chunk carry is held in a register between chunks.
- Used where a full-width lookahead adder would cost too much area.
- Valid/ready handshakes on both the operand side and the result side.

---
 rtl/cla_multiword_sequencer_pkg.sv | 30 +++
 rtl/cla_multiword_sequencer_adder.sv | 45 ++++
 rtl/cla_multiword_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cla_multiword_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : cla_multiword_sequencer_pkg
// Description : State encodings and sizing helper shared by the multi-word
//               chunked adder sequencer.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package cla_multiword_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, never smaller than 1 so a counter always has a bit
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_multiword_sequencer_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : Carry_LookAhead_Adder
// Description : Carry-less WIDTH-bit lookahead adder. Sum is WIDTH+1 bits,
//               the top bit being the carry out. Each carry is formed
//               directly from generate/propagate terms, not rippled.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module Carry_LookAhead_Adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);

    logic [WIDTH-1:0] w_gen;
    logic [WIDTH-1:0] w_prop;
    logic [WIDTH:0]   w_carry;
    logic             w_acc;
    logic             w_prod;

    assign w_gen  = i_a & i_b;
    assign w_prop = i_a ^ i_b;

    // Lookahead carries: c[i+1] = OR_j ( g[j] & p[j+1..i] ), no carry-in
    always_comb begin
        w_carry = '0;
        w_acc   = 1'b0;
        w_prod  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_acc  = 1'b0;
            w_prod = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_acc  = w_acc | (w_prod & w_gen[j]);
                w_prod = w_prod & w_prop[j];
            end
            w_carry[i+1] = w_acc;
        end
    end

    assign o_sum = {w_carry[WIDTH], w_prop ^ w_carry[WIDTH-1:0]};

endmodule
`default_nettype wire

// File: rtl/cla_multiword_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : cla_multiword_sequencer
// Description : Adds two WIDTH*NUM_CHUNKS-bit operands one WIDTH-bit chunk
//               per clock on a single shared lookahead adder, LSB first,
//               with the inter-chunk carry held in a register.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module cla_multiword_sequencer
    import cla_multiword_sequencer_pkg::*;
#(
    parameter  int WIDTH      = 3,
    parameter  int NUM_CHUNKS = 4,
    localparam int TOTAL      = WIDTH * NUM_CHUNKS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [TOTAL-1:0] i_op_a,
    input  logic [TOTAL-1:0] i_op_b,
    input  logic             i_carry_in,
    output logic [TOTAL-1:0] o_result,
    output logic             o_carry_out,
    output logic             o_done_valid,
    input  logic             i_done_ready,
    output logic             o_busy
);

    localparam int IDX_W = clog2_min1(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [TOTAL-1:0] r_op_a;
    logic [TOTAL-1:0] r_op_b;
    logic [TOTAL-1:0] r_result;
    logic             r_carry_out;
    logic             r_done_valid;
    logic             r_busy;
    logic             r_start_ready;

    logic [WIDTH:0]   w_add_a;
    logic [WIDTH:0]   w_add_b;
    logic [WIDTH+1:0] w_add_sum;
    logic [WIDTH-1:0] w_chunk_sum;
    logic             w_new_carry;

    // The adder has no carry input: a forced 1 in bit 0 of one operand
    // paired with the carry in bit 0 of the other makes bit 0 carry out
    // exactly the stored carry into the real chunk bits.
    assign w_add_a = {r_op_a[r_idx*WIDTH +: WIDTH], 1'b1};
    assign w_add_b = {r_op_b[r_idx*WIDTH +: WIDTH], r_carry};

    Carry_LookAhead_Adder #(
        .WIDTH (WIDTH + 1)
    ) u_adder (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .o_sum (w_add_sum)
    );

    assign w_chunk_sum = w_add_sum[WIDTH:1];
    assign w_new_carry = w_add_sum[WIDTH+1];

    // Sequencer FSM: accept operands, walk the chunks, hold result until taken
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_carry       <= 1'b0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_result      <= '0;
            r_carry_out   <= 1'b0;
            r_done_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start_valid && r_start_ready) begin
                        r_op_a        <= i_op_a;
                        r_op_b        <= i_op_b;
                        r_carry       <= i_carry_in;
                        r_idx         <= '0;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result[r_idx*WIDTH +: WIDTH] <= w_chunk_sum;
                    r_carry <= w_new_carry;
                    if (r_idx == C_LAST_IDX) begin
                        r_carry_out  <= w_new_carry;
                        r_idx        <= '0;
                        r_done_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_done_ready) begin
                        r_done_valid  <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_idx         <= '0;
                    r_done_valid  <= 1'b0;
                    r_busy        <= 1'b0;
                    r_start_ready <= 1'b1;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_start_ready = r_start_ready;
    assign o_result      = r_result;
    assign o_carry_out   = r_carry_out;
    assign o_done_valid  = r_done_valid;
    assign o_busy        = r_busy;

endmodule
`default_nettype wire
